// File: rtl/rx_frame_ctrl.sv
// RX frame sequencer: SFD hunt, PHR capture and PSDU byte assembly
// into FIFO writes, with length, overflow and timeout abort.
module rx_frame_ctrl #(
    parameter logic [7:0]  SFD_VALUE   = 8'hA7,
    parameter int unsigned MAX_LEN     = 127,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_en,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       fifo_full,
    output logic [7:0] fifo_wdata,
    output logic       fifo_wr,
    output logic       sfd_det,
    output logic       rx_busy,
    output logic       rx_done,
    output logic       rx_err,
    output logic [1:0] err_code,
    output logic [6:0] frame_len
);

    localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, HUNT, LEN, PAYLOAD} state_t;

    state_t        state_q, state_d;
    logic [15:0]   win_q, win_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [6:0]    byte_cnt_q, byte_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          wr_q, wr_d;
    logic          sfd_q, sfd_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;
    logic [6:0]    len_q, len_d;

    logic [15:0] win_shift;
    logic [7:0]  new_byte;
    logic [6:0]  phr_len;
    logic        len_bad;

    assign win_shift = {bit_in, win_q[15:1]};
    assign new_byte  = win_shift[15:8];
    assign phr_len   = new_byte[6:0];
    assign len_bad   = (phr_len == 7'd0) || (32'(phr_len) > MAX_LEN);

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        tmo_d      = tmo_q;
        wdata_d    = wdata_q;
        len_d      = len_q;
        code_d     = code_q;
        wr_d       = 1'b0;
        sfd_d      = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        if (!rx_en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = HUNT;
                    win_d   = '0;
                end
                HUNT: begin
                    if (bit_valid) begin
                        win_d = win_shift;
                        if (win_shift == {SFD_VALUE, 8'h00}) begin
                            state_d   = LEN;
                            sfd_d     = 1'b1;
                            code_d    = 2'b00;
                            bit_cnt_d = 3'd0;
                            tmo_d     = '0;
                        end
                    end
                end
                LEN, PAYLOAD: begin
                    if (bit_valid) begin
                        win_d     = win_shift;
                        tmo_d     = '0;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == LEN && len_bad) begin
                                err_d   = 1'b1;
                                code_d  = 2'b01;
                                state_d = HUNT;
                                win_d   = '0;
                            end else if (fifo_full) begin
                                err_d   = 1'b1;
                                code_d  = 2'b10;
                                state_d = HUNT;
                                win_d   = '0;
                            end else begin
                                wr_d    = 1'b1;
                                wdata_d = new_byte;
                                if (state_q == LEN) begin
                                    len_d      = phr_len;
                                    byte_cnt_d = phr_len;
                                    state_d    = PAYLOAD;
                                end else begin
                                    byte_cnt_d = byte_cnt_q - 7'd1;
                                    if (byte_cnt_q == 7'd1) begin
                                        done_d  = 1'b1;
                                        state_d = HUNT;
                                        win_d   = '0;
                                    end
                                end
                            end
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        err_d   = 1'b1;
                        code_d  = 2'b11;
                        state_d = HUNT;
                        win_d   = '0;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            win_q      <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            tmo_q      <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            sfd_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_q      <= tmo_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            sfd_q      <= sfd_d;
            done_q     <= done_d;
            err_q      <= err_d;
            code_q     <= code_d;
            len_q      <= len_d;
        end
    end

    assign fifo_wdata = wdata_q;
    assign fifo_wr    = wr_q;
    assign sfd_det    = sfd_q;
    assign rx_busy    = (state_q == LEN) || (state_q == PAYLOAD);
    assign rx_done    = done_q;
    assign rx_err     = err_q;
    assign err_code   = code_q;
    assign frame_len  = len_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: bit-queue reference model checked every
// cycle, plus directed frames with literal expectations.
module tb_rx_frame_ctrl;

    localparam int TMO = 16;
    localparam logic [7:0] SFD = 8'hA7;
    localparam int MAXL = 127;

    logic       clk = 1'b0;
    logic       reset_n, rx_en, bit_in, bit_valid, fifo_full;
    logic [7:0] fifo_wdata;
    logic       fifo_wr, sfd_det, rx_busy, rx_done, rx_err;
    logic [1:0] err_code;
    logic [6:0] frame_len;

    rx_frame_ctrl #(
        .SFD_VALUE  (SFD),
        .MAX_LEN    (MAXL),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_en     (rx_en),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .fifo_full (fifo_full),
        .fifo_wdata(fifo_wdata),
        .fifo_wr   (fifo_wr),
        .sfd_det   (sfd_det),
        .rx_busy   (rx_busy),
        .rx_done   (rx_done),
        .rx_err    (rx_err),
        .err_code  (err_code),
        .frame_len (frame_len)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // reference model: mode 0 idle, 1 hunt, 2 length, 3 payload
    int         m_mode = 0;
    logic       hist[$];
    logic       cur[$];
    int         remaining = 0;
    int         quiet = 0;
    logic       e_wr = 0, e_sfd = 0, e_done = 0, e_err = 0;
    logic [7:0] e_wdata = 0;
    logic [1:0] e_code = 0;
    logic [6:0] e_len = 0;

    task automatic enter_hunt();
        m_mode = 1;
        hist.delete();
        repeat (16) hist.push_back(1'b0);
    endtask

    task automatic abort(input logic [1:0] c);
        e_err  = 1'b1;
        e_code = c;
        enter_hunt();
    endtask

    function automatic bit is_sfd();
        for (int i = 0; i < 8; i++) begin
            if (hist[i] !== 1'b0) return 1'b0;
            if (hist[8+i] !== SFD[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic take(input logic [7:0] b);
        int l;
        l = int'(b) % 128;
        if (m_mode == 2) begin
            if (l == 0 || l > MAXL) abort(2'b01);
            else if (fifo_full) abort(2'b10);
            else begin
                e_len = 7'(l);
                remaining = l;
                e_wr = 1'b1;
                e_wdata = b;
                m_mode = 3;
            end
        end else begin
            if (fifo_full) abort(2'b10);
            else begin
                e_wr = 1'b1;
                e_wdata = b;
                remaining--;
                if (remaining == 0) begin
                    e_done = 1'b1;
                    enter_hunt();
                end
            end
        end
    endtask

    task automatic m_reset();
        m_mode = 0;
        hist.delete();
        cur.delete();
        remaining = 0;
        quiet = 0;
        e_wr = 0; e_sfd = 0; e_done = 0; e_err = 0;
        e_wdata = 0; e_code = 0; e_len = 0;
    endtask

    task automatic m_step();
        logic [7:0] b;
        e_wr = 0; e_sfd = 0; e_done = 0; e_err = 0;
        if (!rx_en) begin
            m_mode = 0;
            return;
        end
        case (m_mode)
            0: enter_hunt();
            1: if (bit_valid) begin
                hist.push_back(bit_in);
                void'(hist.pop_front());
                if (is_sfd()) begin
                    m_mode = 2;
                    e_sfd = 1'b1;
                    e_code = 2'b00;
                    cur.delete();
                    quiet = 0;
                end
            end
            default: if (bit_valid) begin
                quiet = 0;
                cur.push_back(bit_in);
                if (cur.size() == 8) begin
                    for (int i = 0; i < 8; i++) b[i] = cur[i];
                    cur.delete();
                    take(b);
                end
            end else begin
                quiet++;
                if (quiet >= TMO) abort(2'b11);
            end
        endcase
    endtask

    // observation records used by the directed checks
    logic [7:0] wq[$];
    int n_sfd = 0, n_done = 0, n_errp = 0;
    int cyc = 0, last_bv = 0, err_cyc = 0;
    logic       done_wr = 0;
    logic [7:0] done_dat = 0;

    always @(posedge clk) begin
        cyc++;
        if (!reset_n) m_reset();
        else begin
            if (bit_valid) last_bv = cyc;
            m_step();
        end
        #1;
        chk("fifo_wr", int'(fifo_wr), int'(e_wr));
        chk("fifo_wdata", int'(fifo_wdata), int'(e_wdata));
        chk("sfd_det", int'(sfd_det), int'(e_sfd));
        chk("rx_done", int'(rx_done), int'(e_done));
        chk("rx_err", int'(rx_err), int'(e_err));
        chk("err_code", int'(err_code), int'(e_code));
        chk("frame_len", int'(frame_len), int'(e_len));
        chk("rx_busy", int'(rx_busy), int'(m_mode >= 2));
        chk("pulse_excl",
            int'(sfd_det) + int'(rx_done) + int'(rx_err) > 1, 0);
        if (fifo_wr) wq.push_back(fifo_wdata);
        if (sfd_det) n_sfd++;
        if (rx_done) begin
            n_done++;
            done_wr = fifo_wr;
            done_dat = fifo_wdata;
        end
        if (rx_err) begin
            n_errp++;
            err_cyc = cyc;
        end
    end

    task automatic clr();
        wq.delete();
        n_sfd = 0; n_done = 0; n_errp = 0;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_in = b;
        bit_valid = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic send_pre();
        repeat (32) send_bit(1'b0);
        send_byte(SFD);
    endtask

    task automatic chk_wq(input string nm, input int n, input logic [63:0] v);
        chk({nm, "_nwr"}, wq.size(), n);
        for (int i = 0; i < n; i++)
            if (i < wq.size())
                chk({nm, "_wr"}, int'(wq[i]), int'(v[8*(n-1-i) +: 8]));
    endtask

    initial begin
        reset_n = 0; rx_en = 0; bit_in = 0;
        bit_valid = 0; fifo_full = 0;
        repeat (3) @(negedge clk);
        chk("rst_wr", int'(fifo_wr), 0);
        chk("rst_busy", int'(rx_busy), 0);
        chk("rst_code", int'(err_code), 0);
        chk("rst_len", int'(frame_len), 0);
        reset_n = 1;
        rx_en = 1;
        repeat (2) @(negedge clk);

        // nominal frame
        clr();
        send_pre();
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        repeat (2) @(negedge clk);
        chk("nom_sfd", n_sfd, 1);
        chk_wq("nom", 4, 64'h03112233);
        chk("nom_done", n_done, 1);
        chk("nom_done_wr", int'(done_wr), 1);
        chk("nom_done_dat", int'(done_dat), 8'h33);
        chk("nom_len", int'(frame_len), 3);
        chk("nom_code", int'(err_code), 0);
        chk("nom_busy", int'(rx_busy), 0);

        // bad length: 0x00 then 0x80
        clr();
        send_pre();
        send_byte(8'h00);
        repeat (2) @(negedge clk);
        chk("bl0_err", n_errp, 1);
        chk("bl0_code", int'(err_code), 1);
        chk("bl0_busy", int'(rx_busy), 0);
        send_pre();
        send_byte(8'h80);
        repeat (2) @(negedge clk);
        chk("bl80_err", n_errp, 2);
        chk("bl80_code", int'(err_code), 1);
        chk("bl_nwr", wq.size(), 0);
        chk("bl_len", int'(frame_len), 3);

        // overflow on third payload byte
        clr();
        send_pre();
        send_byte(8'h05);
        send_byte(8'hA1);
        send_byte(8'hB2);
        fifo_full = 1;
        send_byte(8'hC4);
        repeat (2) @(negedge clk);
        fifo_full = 0;
        chk_wq("ovf", 3, 64'h05A1B2);
        chk("ovf_err", n_errp, 1);
        chk("ovf_code", int'(err_code), 2);
        chk("ovf_done", n_done, 0);
        chk("ovf_busy", int'(rx_busy), 0);

        // timeout after two payload bytes
        clr();
        send_pre();
        send_byte(8'h04);
        send_byte(8'h12);
        send_byte(8'h34);
        repeat (30) @(negedge clk);
        chk_wq("tmo", 3, 64'h041234);
        chk("tmo_err", n_errp, 1);
        chk("tmo_code", int'(err_code), 3);
        chk("tmo_dist", err_cyc - last_bv, TMO);
        chk("tmo_busy", int'(rx_busy), 0);

        // rx_en drop mid-payload
        clr();
        send_pre();
        send_byte(8'h03);
        send_byte(8'h5A);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        @(negedge clk);
        rx_en = 0;
        repeat (5) @(negedge clk);
        chk("en_busy", int'(rx_busy), 0);
        chk("en_pulses", n_done + n_errp, 0);
        chk_wq("en", 2, 64'h035A);
        rx_en = 1;

        // async reset mid-frame
        send_pre();
        send_byte(8'h02);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        @(negedge clk);
        #2 reset_n = 0;
        #1;
        chk("ar_wr", int'(fifo_wr), 0);
        chk("ar_wdata", int'(fifo_wdata), 0);
        chk("ar_sfd", int'(sfd_det), 0);
        chk("ar_busy", int'(rx_busy), 0);
        chk("ar_done", int'(rx_done), 0);
        chk("ar_err", int'(rx_err), 0);
        chk("ar_code", int'(err_code), 0);
        chk("ar_len", int'(frame_len), 0);
        @(negedge clk);
        reset_n = 1;
        repeat (2) @(negedge clk);
        clr();
        send_pre();
        send_byte(8'h02);
        send_byte(8'hC3);
        send_byte(8'h3C);
        repeat (2) @(negedge clk);
        chk_wq("post", 3, 64'h02C33C);
        chk("post_done", n_done, 1);
        chk("post_len", int'(frame_len), 2);

        // false SFD: only seven zeros ahead of A7
        clr();
        send_byte(8'hFF);
        send_byte(8'h80);
        send_byte(SFD);
        repeat (2) @(negedge clk);
        chk("fsfd_none", n_sfd, 0);
        send_pre();
        chk("fsfd_real", n_sfd, 1);
        send_byte(8'h01);
        send_byte(8'h99);
        repeat (2) @(negedge clk);
        chk_wq("fsfd", 2, 64'h0199);
        chk("fsfd_done", n_done, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
